// File: rtl/bids_nway_pkg.sv
// Shared types and code constants for the n-way sealed-bid auction block.
// States, control opcodes and the two error-code alphabets live here.
package bids_nway_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ROUND    = 2'd2,
    ST_SETTLE   = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP         = 4'd0,
    OP_UNLOCK      = 4'd1,
    OP_LOCK        = 4'd2,
    OP_LOAD_BAL    = 4'd3,
    OP_SET_MASK    = 4'd4,
    OP_SET_RESERVE = 4'd5,
    OP_SET_COST    = 4'd6
  } op_t;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_BAD_KEY  = 3'b001;
  localparam logic [2:0] ERR_UNLOCKED = 3'b010;
  localparam logic [2:0] ERR_STATE    = 3'b011;
  localparam logic [2:0] ERR_BAD_OP   = 3'b100;
  localparam logic [2:0] ERR_START    = 3'b101;

  localparam logic [1:0] BERR_NONE   = 2'b00;
  localparam logic [1:0] BERR_MASKED = 2'b01;
  localparam logic [1:0] BERR_FUNDS  = 2'b10;
  localparam logic [1:0] BERR_STATE  = 2'b11;

endpackage

// File: rtl/bids_nway_maxsel.sv
// Argmax over valid bids: highest amount wins, ties resolve to the lowest index.
module bids_nway_maxsel #(
  parameter int N = 4,
  parameter int W = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]        valid,
  input  logic [N-1:0][W-1:0] amt,
  output logic                found,
  output logic [IW-1:0]       idx,
  output logic [W-1:0]        max_amt
);

  // NOTE: combinational logic uses blocking assignments and gives every output a
  // default first, so the loop-carried values chain correctly and no latch is inferred.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    max_amt = '0;
    for (int i = 0; i < N; i++) begin
      // Strict '>' keeps the earlier (lower) index on equal amounts.
      if (valid[i] && (!found || amt[i] > max_amt)) begin
        found   = 1'b1;
        idx     = IW'(i);
        max_amt = amt[i];
      end
    end
  end

endmodule

// File: rtl/bids_nway.sv
// N-way auction: keyed control interface, per-bidder balances and fees,
// round open/close on C_start edges, and a single-cycle settle with reserve check.
module bids_nway
  import bids_nway_pkg::*;
#(
  parameter int N_BIDDERS = 4,
  parameter int AMT_W     = 16,
  parameter int BAL_W     = 32,
  localparam int SEL_W    = $clog2(N_BIDDERS)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_BIDDERS-1:0]            bid,
  input  logic [N_BIDDERS-1:0][AMT_W-1:0] bidAmt,
  input  logic [N_BIDDERS-1:0]            retract,
  input  logic                            C_start,
  input  logic [3:0]                      C_op,
  input  logic [SEL_W-1:0]                C_sel,
  input  logic [BAL_W-1:0]                C_data,
  output logic [N_BIDDERS-1:0]            ack,
  output logic [N_BIDDERS-1:0]            win,
  output logic [N_BIDDERS-1:0][1:0]       bidErr,
  output logic [2:0]                      err,
  output logic [N_BIDDERS-1:0][BAL_W-1:0] balance,
  output logic [BAL_W-1:0]                maxBid,
  output logic                            ready,
  output logic                            roundOver
);

  state_t                            state, next_state;
  logic                              start_q;
  logic [BAL_W-1:0]                  key, reserve, cost;
  logic [N_BIDDERS-1:0]              enable;
  logic [N_BIDDERS-1:0]              held_valid;
  logic [N_BIDDERS-1:0][AMT_W-1:0]   held_amt;
  logic [N_BIDDERS-1:0]              afford;
  logic [2:0]                        err_next;
  logic                              start_rise, start_fall, op_valid, cfg_op;
  logic                              best_found, win_ok;
  logic [SEL_W-1:0]                  best_idx;
  logic [AMT_W-1:0]                  best_amt;

  assign start_rise = C_start & ~start_q;
  assign start_fall = ~C_start & start_q;
  assign op_valid   = (C_op <= OP_SET_COST);
  assign cfg_op     = (C_op >= OP_LOCK) && (C_op <= OP_SET_COST);
  assign ready      = (state == ST_LOCKED);

  bids_nway_maxsel #(.N(N_BIDDERS), .W(AMT_W)) u_maxsel (
    .valid   (held_valid),
    .amt     (held_amt),
    .found   (best_found),
    .idx     (best_idx),
    .max_amt (best_amt)
  );

  assign win_ok = best_found && (BAL_W'(best_amt) >= reserve);

  // One extra bit so cost + amount cannot wrap before the compare.
  always_comb begin
    afford = '0;
    for (int i = 0; i < N_BIDDERS; i++)
      afford[i] = {1'b0, balance[i]} >= ({1'b0, cost} + (BAL_W+1)'(bidAmt[i]));
  end

  always_comb begin
    next_state = state;
    err_next   = ERR_NONE;
    case (state)
      ST_UNLOCKED: begin
        if (!op_valid)                         err_next = ERR_BAD_OP;
        else if (C_op == OP_UNLOCK)            err_next = ERR_UNLOCKED;
        else if (C_op == OP_LOCK)              next_state = ST_LOCKED;
        if (err_next == ERR_NONE && start_rise) err_next = ERR_START;
      end
      ST_LOCKED: begin
        if (!op_valid)                         err_next = ERR_BAD_OP;
        else if (C_op == OP_UNLOCK) begin
          if (C_data == key)                   next_state = ST_UNLOCKED;
          else                                 err_next = ERR_BAD_KEY;
        end
        else if (cfg_op)                       err_next = ERR_STATE;
        if (next_state == ST_LOCKED && start_rise) next_state = ST_ROUND;
      end
      ST_ROUND: begin
        if (C_op != OP_NOP)                    err_next = ERR_STATE;
        if (start_fall)                        next_state = ST_SETTLE;
      end
      default: begin
        if (C_op != OP_NOP)                    err_next = ERR_STATE;
        next_state = ST_LOCKED;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_UNLOCKED;
      start_q <= 1'b0;
      err     <= ERR_NONE;
      key     <= '0;
      enable  <= '1;
      reserve <= '0;
      cost    <= BAL_W'(1);
    end else begin
      state   <= next_state;
      start_q <= C_start;
      err     <= err_next;
      if (state == ST_UNLOCKED) begin
        case (C_op)
          OP_LOCK:        key     <= C_data;
          OP_SET_MASK:    enable  <= C_data[N_BIDDERS-1:0];
          OP_SET_RESERVE: reserve <= C_data;
          OP_SET_COST:    cost    <= C_data;
          default: ;
        endcase
      end
    end
  end

  // NOTE: held_amt is deliberately left out of reset; held_valid qualifies it,
  // while balances are architecturally visible and must clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      balance    <= '0;
      held_valid <= '0;
      maxBid     <= '0;
      ack        <= '0;
      win        <= '0;
      bidErr     <= '0;
      roundOver  <= 1'b0;
    end else begin
      ack       <= '0;
      win       <= '0;
      bidErr    <= '0;
      roundOver <= 1'b0;
      if (state == ST_LOCKED && next_state == ST_ROUND) held_valid <= '0;
      for (int i = 0; i < N_BIDDERS; i++) begin
        if (state == ST_UNLOCKED && C_op == OP_LOAD_BAL && C_sel == SEL_W'(i))
          balance[i] <= C_data;
        if (bid[i]) begin
          if (state != ST_ROUND)  bidErr[i] <= BERR_STATE;
          else if (!enable[i])    bidErr[i] <= BERR_MASKED;
          else if (!afford[i])    bidErr[i] <= BERR_FUNDS;
          else begin
            ack[i]        <= 1'b1;
            balance[i]    <= balance[i] - cost;
            held_valid[i] <= 1'b1;
            held_amt[i]   <= bidAmt[i];
          end
        end else if (retract[i] && state == ST_ROUND) begin
          held_valid[i] <= 1'b0;
        end
        if (state == ST_SETTLE && win_ok && best_idx == SEL_W'(i)) begin
          win[i]     <= 1'b1;
          balance[i] <= balance[i] - BAL_W'(best_amt);
        end
      end
      if (state == ST_SETTLE) begin
        roundOver <= 1'b1;
        maxBid    <= win_ok ? BAL_W'(best_amt) : '0;
      end
    end
  end

endmodule

// File: tb/tb_bids_nway.sv
// Directed bench for bids_nway (4 bidders): hand-computed balances, errors and winners.
module tb_bids_nway;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       bid, retract, ack, win;
  logic [3:0][15:0] bid_amt;
  logic [3:0][1:0]  bid_err;
  logic             c_start;
  logic [3:0]       c_op;
  logic [1:0]       c_sel;
  logic [31:0]      c_data;
  logic [2:0]       err;
  logic [3:0][31:0] balance;
  logic [31:0]      max_bid;
  logic             ready, round_over;

  int total = 0;
  int bad   = 0;

  bids_nway #(.N_BIDDERS(4), .AMT_W(16), .BAL_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bid       (bid),
    .bidAmt    (bid_amt),
    .retract   (retract),
    .C_start   (c_start),
    .C_op      (c_op),
    .C_sel     (c_sel),
    .C_data    (c_data),
    .ack       (ack),
    .win       (win),
    .bidErr    (bid_err),
    .err       (err),
    .balance   (balance),
    .maxBid    (max_bid),
    .ready     (ready),
    .roundOver (round_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] data, input logic [1:0] sel = 2'd0);
    c_op = op; c_data = data; c_sel = sel;
    step();
    c_op = 4'd0; c_data = '0; c_sel = '0;
  endtask

  initial begin
    reset_n = 1'b0; bid = '0; retract = '0; bid_amt = '0;
    c_start = 1'b0; c_op = '0; c_sel = '0; c_data = '0;
    step(); step();
    check("rst_ready", ready, 0);
    check("rst_err", err, 0);
    check("rst_maxbid", max_bid, 0);
    check("rst_bal0", balance[0], 0);
    check("rst_ack", ack, 0);
    reset_n = 1'b1;

    // Basic round with a tie between bidders 1 and 2.
    for (int i = 0; i < 4; i++) do_op(4'd3, 32'h100, 2'(i));
    check("load_bal1", balance[1], 32'h100);
    do_op(4'd2, 32'hA5);
    check("lock_err", err, 0);
    check("lock_ready", ready, 1);
    c_start = 1'b1; step();
    check("round_ready", ready, 0);
    bid = 4'b0110; bid_amt[1] = 16'h50; bid_amt[2] = 16'h50; step(); bid = '0;
    check("tie_ack", ack, 4'b0110);
    check("tie_bal1_fee", balance[1], 32'hFF);
    c_start = 1'b0; step();
    check("settle_no_pulse", round_over, 0);
    step();
    check("tie_over", round_over, 1);
    check("tie_win", win, 4'b0010);
    check("tie_maxbid", max_bid, 32'h50);
    check("tie_bal1", balance[1], 32'hAF);
    check("tie_bal2", balance[2], 32'hFF);
    check("tie_ready", ready, 1);
    step();
    check("over_pulse", round_over, 0);
    check("maxbid_hold", max_bid, 32'h50);
    bid = 4'b0001; step(); bid = '0;
    check("bid_locked_err", bid_err, 8'b0000_0011);

    // Key and opcode errors.
    do_op(4'd1, 32'h11);
    check("bad_key_err", err, 3'b001);
    check("bad_key_ready", ready, 1);
    do_op(4'd1, 32'hA5);
    check("unlock_err", err, 3'b000);
    check("unlock_ready", ready, 0);
    do_op(4'd1, 32'hA5);
    check("reunlock_err", err, 3'b010);
    do_op(4'd9, 32'h0);
    check("invalid_op_err", err, 3'b100);
    c_start = 1'b1; step();
    check("start_unlocked_err", err, 3'b101);
    c_start = 1'b0; step();
    check("start_fall_err", err, 3'b000);
    check("start_ignored", ready, 0);

    // Mask, insufficient funds, control op in ROUND, concurrent accept.
    do_op(4'd4, 32'hD);
    do_op(4'd3, 32'h10, 2'd0);
    check("load_bal0", balance[0], 32'h10);
    do_op(4'd2, 32'hA5);
    do_op(4'd6, 32'h5);
    check("cfg_locked_err", err, 3'b011);
    c_start = 1'b1; step();
    bid = 4'b1011; bid_amt[0] = 16'h10; bid_amt[1] = 16'h10; bid_amt[3] = 16'h20;
    c_op = 4'd2; step(); bid = '0; c_op = '0;
    check("mask_ack", ack, 4'b1000);
    check("mask_funds_err", bid_err, 8'b0000_0110);
    check("op_in_round_err", err, 3'b011);
    check("funds_bal0", balance[0], 32'h10);
    check("acc_bal3", balance[3], 32'hFF);
    c_start = 1'b0; step(); step();
    check("b3_win", win, 4'b1000);
    check("b3_maxbid", max_bid, 32'h20);
    check("b3_bal", balance[3], 32'hDF);

    // Reserve not met: fee charged, no winner.
    do_op(4'd1, 32'hA5);
    do_op(4'd4, 32'hF);
    do_op(4'd5, 32'h80);
    do_op(4'd2, 32'hA5);
    c_start = 1'b1; step();
    bid = 4'b1000; bid_amt[3] = 16'h7F; step(); bid = '0;
    check("rsv_ack", ack, 4'b1000);
    c_start = 1'b0; step(); step();
    check("rsv_over", round_over, 1);
    check("rsv_win", win, 4'b0000);
    check("rsv_maxbid", max_bid, 0);
    check("rsv_bal3", balance[3], 32'hDE);

    // Retract without refund; bid+retract on the same bidder keeps the bid.
    do_op(4'd1, 32'hA5);
    do_op(4'd5, 32'h0);
    do_op(4'd3, 32'h100, 2'd0);
    do_op(4'd2, 32'hA5);
    c_start = 1'b1; step();
    bid = 4'b0111; bid_amt[0] = 16'h60; bid_amt[1] = 16'h30; bid_amt[2] = 16'h40; step();
    check("ret_ack", ack, 4'b0111);
    bid = 4'b0010; bid_amt[1] = 16'h20; retract = 4'b0011; step(); bid = '0; retract = '0;
    check("bidret_ack", ack, 4'b0010);
    check("bidret_bal1", balance[1], 32'hAD);
    c_start = 1'b0; step(); step();
    check("ret_win", win, 4'b0100);
    check("ret_maxbid", max_bid, 32'h40);
    check("ret_bal0", balance[0], 32'hFF);
    check("ret_bal2", balance[2], 32'hBE);
    c_start = 1'b1; step();
    bid = 4'b0010; bid_amt[1] = 16'h10; retract = 4'b0010; step(); bid = '0; retract = '0;
    c_start = 1'b0; step(); step();
    check("keep_win", win, 4'b0010);
    check("keep_maxbid", max_bid, 32'h10);
    check("keep_bal1", balance[1], 32'h9C);

    // Reset in the middle of a round.
    c_start = 1'b1; step();
    bid = 4'b0100; bid_amt[2] = 16'h10; step(); bid = '0;
    check("mid_ack", ack, 4'b0100);
    check("mid_bal2", balance[2], 32'hBD);
    reset_n = 1'b0; step();
    reset_n = 1'b1; c_start = 1'b0;
    check("mrst_ready", ready, 0);
    check("mrst_bal2", balance[2], 0);
    check("mrst_maxbid", max_bid, 0);
    check("mrst_over", round_over, 0);
    check("mrst_win", win, 0);
    step(); step();
    check("mrst_no_settle", round_over, 0);
    do_op(4'd1, 32'h0);
    check("mrst_unlocked", err, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bids_nway.md
BIDS_NWAY -- requirements
Module: bids_nway

Interface
REQ-001 SHALL have parameter N_BIDDERS, default 4, number of bidder channels (2..8).
REQ-002 SHALL have parameter AMT_W, default 16, bid amount width.
REQ-003 SHALL have parameter BAL_W, default 32, balance, max-bid and C_data width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- bid  in  N_BIDDERS  per-bidder bid strobe
- bidAmt  in  N_BIDDERS x AMT_W  per-bidder amount
- retract  in  N_BIDDERS  per-bidder retract strobe
- C_start  in  1  round-open level
- C_op  in  4  control opcode
- C_sel  in  clog2(N_BIDDERS)  bidder index for LOAD_BAL
- C_data  in  BAL_W  control operand
- ack  out  N_BIDDERS  bid-accepted pulse
- win  out  N_BIDDERS  winner pulse
- bidErr  out  N_BIDDERS x 2  per-bidder error
- err  out  3  control error
- balance  out  N_BIDDERS x BAL_W  current balances
- maxBid  out  BAL_W  winning amount of last round
- ready  out  1  able to open a round
- roundOver  out  1  settle pulse

Function
REQ-006 SHALL implement states UNLOCKED, LOCKED, ROUND, SETTLE; reset state UNLOCKED.
REQ-007 Opcodes: 0 NOP; 1 UNLOCK (C_data must equal key); 2 LOCK (key <= C_data); 3 LOAD_BAL (balance[C_sel] <= C_data); 4 SET_MASK (enable <= C_data[N_BIDDERS-1:0]); 5 SET_RESERVE; 6 SET_COST (per-bid fee); 7..15 invalid.
REQ-008 Ops 2..6 SHALL act only in UNLOCKED; effect visible next cycle.
REQ-009 err SHALL pulse one cycle after the offending op cycle: 001 UNLOCK with wrong key (stay LOCKED); 010 UNLOCK while UNLOCKED; 011 ops 2..6 outside UNLOCKED, or any non-NOP op in ROUND/SETTLE; 100 invalid op; 101 C_start rising edge while UNLOCKED (ignored). Otherwise 000.
REQ-010 ready SHALL be 1 only in LOCKED.
REQ-011 C_start rising edge in LOCKED SHALL enter ROUND next cycle, clearing all held bids.
REQ-012 In ROUND, bid[i] SHALL be accepted iff enable[i] and balance[i] >= cost + bidAmt[i] (BAL_W+1-bit compare); on accept, ack[i]=1 next cycle, balance[i] -= cost, held bid[i] <= bidAmt[i] (replaces prior bid).
REQ-013 Rejected bid SHALL give ack[i]=0 and bidErr[i] next cycle: 01 masked; 10 insufficient balance; 11 bid outside ROUND; masked takes priority over balance.
REQ-014 retract[i] in ROUND SHALL invalidate held bid[i] without refund; retract with no held bid is ignored; bid and retract same cycle: bid processed, retract ignored.
REQ-015 Any number of bidders SHALL be processed in the same cycle independently.
REQ-016 C_start falling in ROUND SHALL enter SETTLE for one cycle, then LOCKED; bids arriving during SETTLE get bidErr 11.
REQ-017 SETTLE winner = valid held bid with highest amount, ties to lowest index; no winner if none valid or max < reserve.
REQ-018 One cycle after SETTLE: roundOver=1, win[winner]=1, maxBid = winning amount zero-extended (0 if no winner), winner balance -= amount; all one-cycle pulses except maxBid, which holds.

Reset
REQ-019 On reset_n=0 at clk edge: state UNLOCKED, key 0, enable all 1, reserve 0, cost 1, balances 0, held bids invalid, maxBid 0, all pulses/err/bidErr 0, ready 0; reset mid-round aborts without settlement.

Structure
REQ-020 Package bids_nway_pkg SHALL hold state enum, opcode enum, err and bidErr code constants.
REQ-021 Sub-module bids_nway_maxsel SHALL implement parametrised argmax (valid, amount, lowest-index tie-break) over N_BIDDERS.

Verification (N_BIDDERS=4)
REQ-022 LOAD_BAL 1..4 = 0x100, LOCK key 0xA5, start, bid1=0x50, bid2=0x50, stop -> ack1, ack2; win[1]; maxBid 0x50; balance1 0xAF, balance2 0xFF.
REQ-023 LOCKED, UNLOCK key 0x11 -> err 001, ready stays 1; UNLOCK 0xA5 -> err 000, ready 0.
REQ-024 SET_MASK 0b1101, round, bid1=0x10 -> bidErr1=01, no ack; bid0 balance 0x10, cost 1, amt 0x10 -> bidErr0=10.
REQ-025 SET_RESERVE 0x80, round, bid3=0x7F, stop -> roundOver=1, win=0, maxBid 0, balance3 reduced by cost only.
REQ-026 bid0=0x60, bid2=0x40, retract0, stop -> win[2], maxBid 0x40; same-cycle bid+retract on bidder1 -> bid kept.
REQ-027 reset_n low mid-ROUND -> all outputs reset values next cycle, state UNLOCKED, no roundOver.
